// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - machine-mode CSR file with trap entry/return and registered redirect
module csr_trap_unit #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_1000,
  parameter int          NUM_IRQ     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inst_valid,
  input  logic               CSRRW,
  input  logic               CSRRS,
  input  logic               CSRRC,
  input  logic               CSRRWI,
  input  logic               CSRRSI,
  input  logic               CSRRCI,
  input  logic               ecall,
  input  logic               mret,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        rs1_data,
  input  logic [4:0]         zimm,
  input  logic [31:0]        epc_in,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [31:0]        csr_rdata,
  output logic               flush,
  output logic [31:0]        redirect_pc,
  output logic               mie_global
);

  typedef enum logic {RUN, REDIR} state_t;

  state_t             state_q, state_d;
  logic               mstatus_mie_q, mstatus_mie_d;
  logic               mstatus_mpie_q, mstatus_mpie_d;
  logic [NUM_IRQ-1:0] mie_q, mie_d;
  logic [31:0]        mtvec_q, mtvec_d;
  logic [31:0]        mepc_q, mepc_d;
  logic [31:0]        mcause_q, mcause_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] irq_d_q;
  logic [31:0]        redirect_q, redirect_d;

  logic               run_ok, any_op, imm_op, take_ecall, take_irq, do_mret, csr_we;
  logic [NUM_IRQ-1:0] irq_ready, irq_clr;
  logic [31:0]        irq_idx, src, wdata;

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      12'h300: csr_rdata = {24'h0, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
      12'h304: csr_rdata = {{(32-NUM_IRQ){1'b0}}, mie_q};
      12'h305: csr_rdata = mtvec_q;
      12'h341: csr_rdata = mepc_q;
      12'h342: csr_rdata = mcause_q;
      12'h344: csr_rdata = {{(32-NUM_IRQ){1'b0}}, pending_q};
      default: csr_rdata = 32'h0;
    endcase
  end

  // Highest-index ready interrupt wins; irq_clr is its one-hot clear mask.
  always_comb begin
    irq_ready = pending_q & mie_q;
    irq_idx   = 32'h0;
    irq_clr   = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (irq_ready[i]) begin
        irq_idx    = 32'(i);
        irq_clr    = '0;
        irq_clr[i] = 1'b1;
      end
    end
  end

  assign run_ok     = inst_valid && (state_q == RUN);
  assign any_op     = CSRRW | CSRRS | CSRRC | CSRRWI | CSRRSI | CSRRCI;
  assign imm_op     = CSRRWI | CSRRSI | CSRRCI;
  assign take_ecall = run_ok && ecall;
  assign take_irq   = run_ok && !ecall && mstatus_mie_q && (|irq_ready);
  assign do_mret    = run_ok && !ecall && !take_irq && mret;
  assign csr_we     = run_ok && !ecall && !take_irq && !mret && any_op;

  always_comb begin
    src   = imm_op ? {27'h0, zimm} : rs1_data;
    wdata = src;
    if (CSRRS || CSRRSI) wdata = csr_rdata | src;
    if (CSRRC || CSRRCI) wdata = csr_rdata & ~src;
  end

  always_comb begin
    state_d        = RUN;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    redirect_d     = redirect_q;
    // A new edge and a take of the same bit in one cycle: the take wins.
    pending_d      = (pending_q | (irq & ~irq_d_q)) & ~(take_irq ? irq_clr : '0);

    if (csr_we) begin
      case (csr_addr)
        12'h300: begin
          mstatus_mie_d  = wdata[3];
          mstatus_mpie_d = wdata[7];
        end
        12'h304: mie_d    = wdata[NUM_IRQ-1:0];
        12'h305: mtvec_d  = {wdata[31:2], 2'b00};
        12'h341: mepc_d   = {wdata[31:1], 1'b0};
        12'h342: mcause_d = wdata;
        default: ;
      endcase
    end

    if (take_ecall || take_irq) begin
      state_d        = REDIR;
      mepc_d         = epc_in;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      mcause_d       = take_ecall ? 32'd11 : (32'h8000_0000 | (32'd16 + irq_idx));
      redirect_d     = mtvec_q;
    end else if (do_mret) begin
      state_d        = REDIR;
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
      redirect_d     = mepc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= RUN;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= RESET_MTVEC;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      pending_q      <= '0;
      irq_d_q        <= '0;
      redirect_q     <= 32'h0;
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      pending_q      <= pending_d;
      irq_d_q        <= irq;
      redirect_q     <= redirect_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert ($onehot0({CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI}));
  end

  assign flush       = (state_q == REDIR);
  assign redirect_pc = redirect_q;
  assign mie_global  = mstatus_mie_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb/tb_csr_trap_unit.sv - directed self-checking bench for csr_trap_unit
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst_n, inst_valid;
  logic        CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI, ecall, mret;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data, epc_in;
  logic [4:0]  zimm;
  logic [2:0]  irq;
  logic [31:0] csr_rdata, redirect_pc;
  logic        flush, mie_global;

  int n_assert = 0;
  int n_fail   = 0;

  csr_trap_unit #(.RESET_MTVEC(32'h0000_1000), .NUM_IRQ(3)) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid),
    .CSRRW(CSRRW), .CSRRS(CSRRS), .CSRRC(CSRRC),
    .CSRRWI(CSRRWI), .CSRRSI(CSRRSI), .CSRRCI(CSRRCI),
    .ecall(ecall), .mret(mret), .csr_addr(csr_addr),
    .rs1_data(rs1_data), .zimm(zimm), .epc_in(epc_in), .irq(irq),
    .csr_rdata(csr_rdata), .flush(flush), .redirect_pc(redirect_pc),
    .mie_global(mie_global)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_valid = 1'b0;
    {CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI, ecall, mret} = '0;
    rs1_data = 32'h0;
    zimm     = 5'h0;
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    idle();
    csr_addr = addr;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  initial begin
    idle();
    rst_n = 1'b0; csr_addr = 12'h0; epc_in = 32'h0; irq = 3'b000;
    tick(); tick();
    chk("rst_flush", {31'h0, flush}, 32'h0);
    chk("rst_redirect", redirect_pc, 32'h0);
    chk("rst_mie_global", {31'h0, mie_global}, 32'h0);
    rd(12'h305, 32'h0000_1000, "rst_mtvec");
    rd(12'h300, 32'h0, "rst_mstatus");
    rd(12'h344, 32'h0, "rst_mip");
    rst_n = 1'b1;
    tick();
    chk("run_flush", {31'h0, flush}, 32'h0);

    // CSR read-modify-write ops and WARL masking
    idle(); inst_valid = 1'b1; CSRRW = 1'b1; csr_addr = 12'h341; rs1_data = 32'h0000_2003;
    #1 chk("csrrw_old", csr_rdata, 32'h0);
    tick();
    rd(12'h341, 32'h0000_2002, "mepc_masked");
    chk("no_flush_csr", {31'h0, flush}, 32'h0);
    idle(); inst_valid = 1'b1; CSRRC = 1'b1; csr_addr = 12'h341; rs1_data = 32'h2;
    #1 chk("csrrc_old", csr_rdata, 32'h0000_2002);
    tick();
    rd(12'h341, 32'h0000_2000, "csrrc_new");
    idle(); inst_valid = 1'b1; CSRRS = 1'b1; csr_addr = 12'h305; rs1_data = 32'h3;
    tick();
    rd(12'h305, 32'h0000_1000, "mtvec_masked");
    idle(); inst_valid = 1'b1; CSRRWI = 1'b1; csr_addr = 12'h342; zimm = 5'd5;
    tick();
    rd(12'h342, 32'h5, "csrrwi_mcause");
    idle(); inst_valid = 1'b1; CSRRW = 1'b1; csr_addr = 12'h123; rs1_data = 32'hffff_ffff;
    #1 chk("unmapped_old", csr_rdata, 32'h0);
    tick();
    rd(12'h123, 32'h0, "unmapped_read");
    idle(); inst_valid = 1'b0; CSRRW = 1'b1; csr_addr = 12'h342; rs1_data = 32'h77;
    tick();
    rd(12'h342, 32'h5, "bubble_no_write");

    // Enable interrupts, then two simultaneous edges
    idle(); inst_valid = 1'b1; CSRRSI = 1'b1; csr_addr = 12'h300; zimm = 5'd8;
    tick();
    chk("mie_set", {31'h0, mie_global}, 32'h1);
    idle(); inst_valid = 1'b1; CSRRSI = 1'b1; csr_addr = 12'h304; zimm = 5'd7;
    tick();
    rd(12'h304, 32'h7, "mie_reg");
    irq = 3'b101;
    tick();
    irq = 3'b000;
    rd(12'h344, 32'h5, "mip_both");
    idle(); inst_valid = 1'b1; epc_in = 32'h0000_0040;
    tick();
    chk("irq2_flush", {31'h0, flush}, 32'h1);
    chk("irq2_redirect", redirect_pc, 32'h0000_1000);
    chk("irq2_mie_global", {31'h0, mie_global}, 32'h0);
    rd(12'h342, 32'h8000_0012, "irq2_mcause");
    rd(12'h341, 32'h0000_0040, "irq2_mepc");
    rd(12'h300, 32'h0000_0080, "irq2_mstatus");
    rd(12'h344, 32'h1, "irq2_mip_left");
    tick();
    chk("redir_one_cycle", {31'h0, flush}, 32'h0);

    // mret then pending irq0 taken on next valid cycle
    idle(); inst_valid = 1'b1; mret = 1'b1; epc_in = 32'h0000_0044;
    tick();
    chk("mret_flush", {31'h0, flush}, 32'h1);
    chk("mret_redirect", redirect_pc, 32'h0000_0040);
    chk("mret_mie_global", {31'h0, mie_global}, 32'h1);
    rd(12'h300, 32'h0000_0088, "mret_mstatus");
    tick();
    idle(); inst_valid = 1'b1; epc_in = 32'h0000_0040;
    tick();
    chk("irq0_flush", {31'h0, flush}, 32'h1);
    rd(12'h342, 32'h8000_0010, "irq0_mcause");
    rd(12'h344, 32'h0, "irq0_mip");
    tick();

    // ecall beats a ready interrupt
    idle(); inst_valid = 1'b1; CSRRSI = 1'b1; csr_addr = 12'h300; zimm = 5'd8;
    tick();
    idle(); irq = 3'b010;
    tick();
    irq = 3'b000;
    idle(); inst_valid = 1'b1; ecall = 1'b1; epc_in = 32'h0000_0100;
    tick();
    chk("ecall_flush", {31'h0, flush}, 32'h1);
    chk("ecall_redirect", redirect_pc, 32'h0000_1000);
    rd(12'h342, 32'd11, "ecall_mcause");
    rd(12'h341, 32'h0000_0100, "ecall_mepc");
    rd(12'h344, 32'h2, "ecall_pending_kept");
    idle(); inst_valid = 1'b1; CSRRW = 1'b1; csr_addr = 12'h300; rs1_data = 32'h8;
    tick();
    rd(12'h300, 32'h0000_0080, "redir_write_ignored");

    // CSR write loses to an interrupt taken in the same cycle
    idle(); inst_valid = 1'b1; mret = 1'b1;
    tick();
    chk("mret2_redirect", redirect_pc, 32'h0000_0100);
    idle();
    tick();
    idle(); inst_valid = 1'b1; CSRRW = 1'b1; csr_addr = 12'h300; rs1_data = 32'h0; epc_in = 32'h0000_0200;
    #1 chk("irq1_old_mstatus", csr_rdata, 32'h0000_0088);
    tick();
    chk("irq1_flush", {31'h0, flush}, 32'h1);
    rd(12'h342, 32'h8000_0011, "irq1_mcause");
    rd(12'h300, 32'h0000_0080, "irq1_mstatus");
    rd(12'h341, 32'h0000_0200, "irq1_mepc");

    // Reset during REDIR
    rst_n = 1'b0;
    tick();
    chk("rst_redir_flush", {31'h0, flush}, 32'h0);
    chk("rst_redir_redirect", redirect_pc, 32'h0);
    rd(12'h305, 32'h0000_1000, "rst2_mtvec");
    rd(12'h341, 32'h0, "rst2_mepc");
    rd(12'h342, 32'h0, "rst2_mcause");
    rd(12'h304, 32'h0, "rst2_mie");
    rd(12'h300, 32'h0, "rst2_mstatus");
    rst_n = 1'b1;
    tick();
    chk("rst2_run_flush", {31'h0, flush}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Execution-side counterpart of the instruction decoder. Consumes the decoded CSR, ecall and mret strobes and carries them out.
- Holds the machine-mode CSR file and latches three external interrupt lines.
- Arbitrates trap entry and return, and issues a registered one-cycle PC redirect/flush to the pipeline front end.
- Sits beside the WB stage of the interrupt pipeline.

Parameters:
- RESET_MTVEC, 32'h0000_1000, mtvec value after reset.
- NUM_IRQ, 3, number of external interrupt lines (priority: highest index wins).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- inst_valid  in  1  WB-stage instruction is real (not a bubble)
- CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI  in  1 each  one-hot decoded CSR op
- ecall  in  1  decoded ecall
- mret  in  1  decoded mret
- csr_addr  in  12  CSR address (inst[31:20])
- rs1_data  in  32  register source operand
- zimm  in  5  immediate source (inst[19:15]), zero-extended to 32 bits
- epc_in  in  32  PC of the WB-stage instruction
- irq  in  NUM_IRQ  external interrupt request lines, level, synchronous to clk
- csr_rdata  out  32  old CSR value (rd writeback), combinational
- flush  out  1  registered pulse: squash younger instructions
- redirect_pc  out  32  registered target, valid while flush=1
- mie_global  out  1  mstatus.MIE

Behaviour:
- Reset: mstatus=0 (MIE bit3=0, MPIE bit7=0), mie=0, mtvec=RESET_MTVEC, mepc=0, mcause=0, pending=0, irq_d=0, flush=0, redirect_pc=0, state=RUN.
- CSR map: 0x300 mstatus (bits 3 and 7 writable, others read 0); 0x304 mie (bits [NUM_IRQ-1:0]); 0x305 mtvec (bits[1:0] forced 0); 0x341 mepc (bit0 forced 0); 0x342 mcause; 0x344 mip (read-only = pending).
- Unmapped addresses and mip: read 0 (mip reads pending); writes ignored.
- csr_rdata = current value of csr_addr, independent of op.
- Write value, with src = rs1_data or {27'b0,zimm}:
  - W: src
  - S: old|src
  - C: old&~src
- Write commits at the clock edge only when inst_valid=1, state=RUN, and no trap is taken that cycle.
- Interrupt latch: irq_d<=irq. On rising edge (irq & ~irq_d), set pending[k]. pending[k] clears only when interrupt k is taken. A set and a clear of the same bit in one cycle: clear wins.
- Take interrupt when state=RUN, inst_valid=1, MIE=1 and (pending & mie)!=0. The highest set index k wins.
- Event priority in one cycle: ecall > interrupt > mret > CSR op. The losing instruction's effects are suppressed.
- Trap entry (ecall or interrupt):
  - mepc<=epc_in
  - MPIE<=MIE, MIE<=0
  - mcause<=32'd11 for ecall, or 32'h8000_0000|(16+k) for interrupt k
  - redirect_pc<=mtvec
  - for an interrupt, the WB instruction is squashed and re-executed after mret
- mret: MIE<=MPIE, MPIE<=1, redirect_pc<=mepc.
- State machine RUN/REDIR:
  - RUN to REDIR on any trap or mret; flush=1 for exactly the REDIR cycle.
  - REDIR to RUN unconditionally next cycle.
  - In REDIR: inst_valid is ignored (no CSR writes, no traps); pending still latches.
- Latency: event in cycle N gives flush and redirect_pc in cycle N+1. The new MIE is visible in N+1.
- Multiple CSR op strobes asserted at once is illegal; behaviour is undefined and flagged by assertion.
- Reset asserted in REDIR returns to RUN with flush=0 next cycle. All pending interrupts are lost.

Test Plan:
- Reset then read 0x305 -> csr_rdata=32'h0000_1000. Read 0x300 -> 0. flush stays 0.
- CSRRW 0x341, rs1=32'h0000_2003 -> csr_rdata=0 that cycle; next read of 0x341 = 32'h0000_2002.
- CSRRSI 0x300 zimm=8, then CSRRSI 0x304 zimm=7, then pulse irq[0] and irq[2] in the same cycle, epc_in=32'h0000_0040:
  - next cycle: flush=1, redirect_pc=32'h1000, mcause=32'h8000_0012, mepc=32'h40, MIE=0, MPIE=1
  - mip reads 3'b001 afterwards
- Continue the previous case: mret -> flush=1, redirect_pc=32'h40, MIE=1. Next valid cycle takes irq0 with mcause=32'h8000_0010.
- ecall at epc_in=32'h0000_0100 while pending&mie!=0 and MIE=1 -> mcause=11, mepc=32'h100. pending stays set.
- CSRRW to mstatus issued in the REDIR cycle, or in the same cycle an interrupt is taken -> mstatus unchanged except for the trap-entry update. Deassert rst_n during REDIR -> flush=0 and all CSRs at reset values next cycle.
